// File: rtl/vga_pkg.sv
// Shared types, palette and default 640x480@60 timing for the VGA timing/pattern generator.
package vga_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_EXT   = 2'd3
  } pat_mode_e;

  typedef logic [23:0] rgb_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // 3-bit index {R,G,B} expanded to full-scale channels
  function automatic rgb_t palette(input logic [2:0] idx);
    return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
  endfunction

endpackage

// File: rtl/vga_timing_pattern_gen_if.sv
// Pixel-stream bundle between the generator (master) and the DAC side / pixel source (slave).
interface vga_timing_pattern_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic [1:0]          mode;
  logic [2:0]          solid_color;
  vga_pkg::rgb_t       ext_rgb;
  logic [XW-1:0]       pixel_x;
  logic [YW-1:0]       pixel_y;
  logic                pixel_tick;
  logic                frame_start;
  logic                hsync;
  logic                vsync;
  logic                video_on;
  logic                syncb;
  vga_pkg::rgb_t       rgb_vga;

  modport master (
    input  mode, solid_color, ext_rgb,
    output pixel_x, pixel_y, pixel_tick, frame_start,
           hsync, vsync, video_on, syncb, rgb_vga
  );

  modport slave (
    output mode, solid_color, ext_rgb,
    input  pixel_x, pixel_y, pixel_tick, frame_start,
           hsync, vsync, video_on, syncb, rgb_vga
  );
endinterface

// File: rtl/vga_sync_counter.sv
// Pixel divider, h/v counters and registered sync/active/frame_start decode.
module vga_sync_counter #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic          o_tick,
  output logic [XW-1:0] o_h_cnt,
  output logic [YW-1:0] o_v_cnt,
  output logic          o_first,
  output logic          o_active,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_video_on,
  output logic          o_frame_start
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if ((H_TOT - 1) >= (1 << XW) || (V_TOT - 1) >= (1 << YW) ||
      (H_ACTIVE % 8) != 0 || CLK_DIV < 1) begin : g_bad_cfg
    $error("vga_sync_counter: counter width or timing configuration invalid");
  end

  logic [DW-1:0] r_div;
  logic          r_run;
  logic [XW-1:0] r_h_cnt;
  logic [YW-1:0] r_v_cnt;
  logic          r_hsync, r_vsync, r_video_on, r_frame_start;
  logic          w_h_last, w_v_last, w_hs, w_vs;

  // r_run keeps the tick low through reset even when CLK_DIV==1
  assign o_tick   = r_run && (r_div == DIV_LAST);
  assign w_h_last = (r_h_cnt == XW'(H_TOT - 1));
  assign w_v_last = (r_v_cnt == YW'(V_TOT - 1));
  assign w_hs     = (r_h_cnt >= XW'(H_ACTIVE + H_FP)) && (r_h_cnt < XW'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs     = (r_v_cnt >= YW'(V_ACTIVE + V_FP)) && (r_v_cnt < YW'(V_ACTIVE + V_FP + V_SYNC));
  assign o_active = (r_h_cnt < XW'(H_ACTIVE)) && (r_v_cnt < YW'(V_ACTIVE));
  assign o_first  = (r_h_cnt == '0) && (r_v_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div         <= '0;
      r_run         <= 1'b0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_div         <= (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
      r_frame_start <= o_tick && o_first;
      if (o_tick) begin
        r_hsync    <= w_hs ? SYNC_POL : ~SYNC_POL;
        r_vsync    <= w_vs ? SYNC_POL : ~SYNC_POL;
        r_video_on <= o_active;
        if (w_h_last) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_last ? '0 : r_v_cnt + YW'(1);
        end else begin
          r_h_cnt <= r_h_cnt + XW'(1);
        end
      end
    end
  end

  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_video_on    = r_video_on;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// VGA timing generator with per-frame pattern select (bars, checker, solid, external) and registered RGB.
module vga_timing_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CHK_LOG2 = 5,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  vga_timing_pattern_gen_if.master io_vga
);
  localparam int BAR_W = H_ACTIVE / 8;

  logic          w_tick, w_first, w_active;
  logic [XW-1:0] w_h;
  logic [YW-1:0] w_v;
  logic          w_hsync, w_vsync, w_video_on, w_frame_start;

  vga_sync_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .CLK_DIV(CLK_DIV), .XW(XW), .YW(YW)
  ) u_sync (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .o_tick       (w_tick),
    .o_h_cnt      (w_h),
    .o_v_cnt      (w_v),
    .o_first      (w_first),
    .o_active     (w_active),
    .o_hsync      (w_hsync),
    .o_vsync      (w_vsync),
    .o_video_on   (w_video_on),
    .o_frame_start(w_frame_start)
  );

  logic [XW-1:0] r_bar_px;
  logic [2:0]    r_bar_idx;
  pat_mode_e     r_mode_q, w_mode;
  logic [2:0]    r_colour_q, w_colour;
  rgb_t          r_rgb, w_pat;

  // Pixel (0,0) already uses the selection being latched for the new frame
  assign w_mode   = w_first ? pat_mode_e'(io_vga.mode) : r_mode_q;
  assign w_colour = w_first ? io_vga.solid_color : r_colour_q;

  always_comb begin
    w_pat = '0;
    case (w_mode)
      PAT_BARS:  w_pat = palette(3'd7 - r_bar_idx);
      PAT_CHECK: w_pat = (w_h[CHK_LOG2] ^ w_v[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
      PAT_SOLID: w_pat = palette(w_colour);
      PAT_EXT:   w_pat = io_vga.ext_rgb;
      default:   w_pat = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bar_px   <= '0;
      r_bar_idx  <= '0;
      r_mode_q   <= PAT_BARS;
      r_colour_q <= '0;
      r_rgb      <= '0;
    end else if (w_tick) begin
      if (w_first) begin
        r_mode_q   <= pat_mode_e'(io_vga.mode);
        r_colour_q <= io_vga.solid_color;
      end
      // bar counters advance across the active span and sit at zero through blanking
      if (w_h < XW'(H_ACTIVE)) begin
        if (r_bar_px == XW'(BAR_W - 1)) begin
          r_bar_px  <= '0;
          r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
          r_bar_px <= r_bar_px + XW'(1);
        end
      end else begin
        r_bar_px  <= '0;
        r_bar_idx <= '0;
      end
      r_rgb <= w_active ? w_pat : '0;
    end
  end

  assign io_vga.pixel_x     = w_h;
  assign io_vga.pixel_y     = w_v;
  assign io_vga.pixel_tick  = w_tick;
  assign io_vga.frame_start = w_frame_start;
  assign io_vga.hsync       = w_hsync;
  assign io_vga.vsync       = w_vsync;
  assign io_vga.video_on    = w_video_on;
  assign io_vga.syncb       = 1'b0;
  assign io_vga.rgb_vga     = r_rgb;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Scoreboard bench: a reduced-timing CLK_DIV=2 instance checked pixel by pixel, plus a CLK_DIV=1 timing instance.
module tb_vga_timing_pattern_gen;
  import vga_pkg::*;

  localparam int HA = 64, HF = 4, HS = 6, HB = 6, HT = HA + HF + HS + HB;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_pattern_gen_if #(.XW(10), .YW(10)) vb ();
  vga_timing_pattern_gen_if #(.XW(10), .YW(10)) va ();

  vga_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CLK_DIV(2), .CHK_LOG2(5), .XW(10), .YW(10)
  ) u_dut_b (.i_clk(clk), .i_rst_n(rst_n), .io_vga(vb.master));

  vga_timing_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .CLK_DIV(1), .CHK_LOG2(5), .XW(10), .YW(10)
  ) u_dut_a (.i_clk(clk), .i_rst_n(rst_n), .io_vga(va.master));

  assign vb.ext_rgb     = {vb.pixel_x[7:0], vb.pixel_y[7:0], 8'hA5};
  assign va.mode        = 2'd0;
  assign va.solid_color = 3'd0;
  assign va.ext_rgb     = 24'h0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic hs, vs, von, fs;
    rgb_t rgb;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   k;
  logic [1:0] mq;
  logic [2:0] cq;
  rgb_t prev_rgb;
  rgb_t bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
                    24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000};

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // CLK_DIV=1 instance: after edge e the outputs describe pixel e-2
  int ap, ax, ay;
  always @(negedge clk) begin
    if (rst_n && cyc >= 2) begin
      ap = cyc - 2;
      ax = ap % 14;
      ay = (ap / 14) % 7;
      chk("a_tick",  va.pixel_tick, 1);
      chk("a_hsync", va.hsync, !(ax >= 10 && ax < 12));
      chk("a_vsync", va.vsync, ay != 5);
      chk("a_fs",    va.frame_start, (ax == 0 && ay == 0));
    end
  end

  int last_fs;
  always @(negedge clk) begin
    if (!rst_n) last_fs <= 0;
    else if (vb.frame_start) begin
      if (last_fs != 0) chk("b_fs_period", cyc - last_fs, 2 * FT);
      last_fs <= cyc;
    end
  end

  function automatic rgb_t exp_pix(input logic [1:0] m, input logic [2:0] c, input int x, input int y);
    if (!(x < HA && y < VA)) return 24'h0;
    case (m)
      2'd0:    return palette(3'(7 - x / (HA / 8)));
      2'd1:    return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
      2'd2:    return palette(c);
      default: return {x[7:0], y[7:0], 8'hA5};
    endcase
  endfunction

  task automatic run_ticks(input int n);
    exp_t e;
    int x, y, f;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("b_rgb_hold", vb.rgb_vga, prev_rgb);
        chk("b_fs_lo", vb.frame_start, 0);
      end
      x = k % HT;
      y = (k / HT) % VT;
      f = k / FT;
      if (x == 0 && y == 0) begin
        mq = vb.mode;
        cq = vb.solid_color;
      end
      e.hs  = !(x >= HA + HF && x < HA + HF + HS);
      e.vs  = !(y >= VA + VF && y < VA + VF + VS);
      e.von = (x < HA) && (y < VA);
      e.fs  = (x == 0) && (y == 0);
      e.rgb = exp_pix(mq, cq, x, y);
      sb.push_back(e);
      chk("b_tick", vb.pixel_tick, 1);
      chk("b_px", vb.pixel_x, x);
      chk("b_py", vb.pixel_y, y);
      @(negedge clk);
      e = sb.pop_front();
      chk("b_hsync", vb.hsync, e.hs);
      chk("b_vsync", vb.vsync, e.vs);
      chk("b_von",   vb.video_on, e.von);
      chk("b_fs",    vb.frame_start, e.fs);
      chk("b_rgb",   vb.rgb_vga, e.rgb);
      chk("b_tick_lo", vb.pixel_tick, 0);
      chk("b_syncb", vb.syncb, 0);
      if (f == 0 && y == 0 && x < HA && (x % 8) == 0) chk("bars", vb.rgb_vga, bars[x / 8]);
      if (f == 1 && x == 5 && y == 6)  chk("solid_hold", vb.rgb_vga, 24'h00FF00);
      if (f == 2 && x == 0 && y == 0)  chk("chk_0_0", vb.rgb_vga, 24'h000000);
      if (f == 2 && x == 32 && y == 0) chk("chk_32_0", vb.rgb_vga, 24'hFFFFFF);
      if (f == 3 && x == 3 && y == 2)  chk("ext_3_2", vb.rgb_vga, 24'h0302A5);
      if (f == 3 && x == 70 && y == 0) chk("ext_blank", vb.rgb_vga, 24'h000000);
      prev_rgb = vb.rgb_vga;
      k++;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_hsync"}, vb.hsync, 1);
    chk({tag, "_vsync"}, vb.vsync, 1);
    chk({tag, "_von"},   vb.video_on, 0);
    chk({tag, "_rgb"},   vb.rgb_vga, 0);
    chk({tag, "_fs"},    vb.frame_start, 0);
    chk({tag, "_tick"},  vb.pixel_tick, 0);
    chk({tag, "_px"},    vb.pixel_x, 0);
    chk({tag, "_py"},    vb.pixel_y, 0);
    chk({tag, "_a_tick"}, va.pixel_tick, 0);
    chk({tag, "_a_hsync"}, va.hsync, 1);
  endtask

  initial begin
    vb.mode        = 2'd0;
    vb.solid_color = 3'd0;
    k = 0; mq = '0; cq = '0; prev_rgb = '0;
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    rst_n = 1'b1;

    run_ticks(FT);                       // frame 0: colour bars
    vb.mode = 2'd2; vb.solid_color = 3'b010;
    run_ticks(400);                      // frame 1: solid green
    vb.mode = 2'd1; vb.solid_color = 3'b100;
    run_ticks(FT - 400);                 // mid-frame change must not show yet
    run_ticks(FT / 2);                   // frame 2: checker
    vb.mode = 2'd3;
    run_ticks(FT / 2);
    run_ticks(300);                      // frame 3: external source, ends mid-line

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("midrst");
    repeat (2) @(negedge clk);
    k = 0; prev_rgb = '0;
    vb.mode = 2'd0;
    rst_n = 1'b1;
    run_ticks(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_pattern_gen.md
Name: vga_timing_pattern_gen

Overview:
Parametrised successor to the fixed 640x480 VGA controller. It generates hsync, vsync and video_on from programmable horizontal/vertical timing, and drives a 24-bit RGB pixel stream. The stream is selected per frame from colour bars, checkerboard, a solid palette colour or an external pixel source. It sits between the system clock and the VGA DAC and replaces the controller-plus-decoder pair in the display top level.

Parameters:
H_ACTIVE, 640, visible pixels per line (must be a multiple of 8)
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low)
CLK_DIV, 2, clk cycles per pixel (>=1)
CHK_LOG2, 5, checker square size = 2**CHK_LOG2 pixels
XW, 10, width of pixel_x/h counter
YW, 10, width of pixel_y/v counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
mode  in  2  pattern select: 0 bars, 1 checker, 2 solid, 3 external
solid_color  in  3  palette index for mode 2
ext_rgb  in  24  external pixel {R,G,B}, sampled on pixel tick
pixel_x  out  XW  current h counter (combinational from counter register)
pixel_y  out  YW  current v counter
pixel_tick  out  1  one-clk pulse, pixel advance strobe
frame_start  out  1  registered one-clk pulse, h=0 and v=0 pixel
hsync  out  1  registered horizontal sync
vsync  out  1  registered vertical sync
video_on  out  1  registered active-area flag (DAC blank_n)
syncb  out  1  constant 0 (DAC composite sync unused)
rgb_vga  out  24  registered pixel colour, 0 when blanking

Behaviour:
- Reset, asynchronous and active-low: div counter=0; h_cnt=0; v_cnt=0; bar counters=0; mode_q=0; colour_q=0. Outputs go to hsync=vsync=~SYNC_POL, video_on=0, rgb_vga=0, frame_start=0, pixel_tick=0.
- Divider: counts 0..CLK_DIV-1. pixel_tick=1 when count==CLK_DIV-1. If CLK_DIV==1, pixel_tick is constantly 1 after reset.
- On pixel_tick, h_cnt increments and wraps at H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP. On h wrap, v_cnt increments and wraps at V_TOT (same formula).
- Registered outputs update on pixel_tick and reflect the counter value before the increment. Latency from counter state to pins is 1 pixel tick. Between ticks the outputs hold.
- hsync = SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, otherwise ~SYNC_POL. vsync is defined the same way on v_cnt.
- video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- frame_start is asserted for one clk, with the registered outputs, for the tick where h_cnt==0 and v_cnt==0.
- mode and solid_color are latched into mode_q/colour_q only on the tick where h_cnt==0 and v_cnt==0. A mid-frame change takes effect next frame. No tearing.
- Palette (3-bit to 24-bit): bit2 gives R=FF, bit1 gives G=FF, bit0 gives B=FF, else 00.
- Bars: bar_idx 0..7 and bar_px count 0..H_ACTIVE/8-1.
  - bar_px increments per active pixel.
  - On bar_px wrap, bar_idx increments.
  - Both clear at h_cnt==0.
  - Colour is palette(7-bar_idx): white first, black last.
- Checker: white when pixel_x[CHK_LOG2]^pixel_y[CHK_LOG2] is 1, else black.
- External: rgb_vga takes the ext_rgb value sampled on the same tick as the pixel_x/pixel_y it addresses. The source must be combinational or pre-fetched.
- Blanking: rgb_vga=0 whenever the registered video_on is 0, in every mode.
- Counter widths: XW/YW must hold H_TOT-1/V_TOT-1. An elaboration-time assertion fails otherwise.

Decomposition:
- Package vga_pkg:
  - typedef enum of pattern modes (PAT_BARS, PAT_CHECK, PAT_SOLID, PAT_EXT)
  - 24-bit colour typedef
  - palette function (3-bit to 24-bit)
  - default 640x480@60 timing constants
- One sub-module, vga_sync_counter: divider, h/v counters, sync/active decode, frame_start. The top adds pattern generation and the output register.

Test Plan:
- Small timing (H 8/2/2/2, V 4/1/1/1, CLK_DIV=1), reset released:
  - 14 clks per line, 7 lines per frame (98 clks between frame_start).
  - hsync low exactly at h_cnt 10..11, lagging 1 clk.
  - vsync low for the 14 clks of line 5.
- CLK_DIV=2 defaults: pixel_tick every 2nd clk.
  - frame_start period = 800*525*2 = 840000 clks.
  - hsync low 192 clks per line.
  - video_on high 1280 clks per line.
- mode=0, 8-pixel-wide line: rgb_vga sequence FFFFFF, FFFF00, FF00FF, FF0000, 00FFFF, 00FF00, 0000FF, 000000, then 000000 throughout the porches.
- mode=2 with solid_color=3'b010, switched to mode=1 mid-frame: output stays 00FF00 until the next frame_start, then shows the checker pattern (pixel (0,0) black, pixel (2**CHK_LOG2,0) white).
- mode=3 with ext_rgb = {pixel_x[7:0], pixel_y[7:0], 8'hA5}: pixel at (3,2) outputs 0302A5 one tick later. Blanking region outputs 000000.
- reset deasserted, then asserted mid-line: all outputs return to reset values in the same clk without a clock edge. After release, counting restarts at h=0, v=0 and frame_start pulses after the first tick.
